pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 13 +
 rtl/pipe_stage_reg_if.sv | 27 ++
 rtl/pipe_skid_buf.sv | 126 ++++++++++++
 rtl/pipe_stage_reg.sv | 59 +++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared encodings for pipe_stage_reg: occupancy states and the default bubble control word.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } occ_e;

    localparam int unsigned CTRL_W_DEF = 16;
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP_DEF = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg; slave is the stage, master is the surrounding pipeline.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_ctrl, stall, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, stall, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// Main + skid storage with EMPTY/ONE/TWO occupancy FSM.
// Macro PIPE_SKID_EN enables the skid entry; without it the buffer holds a single entry.
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output occ_e              o_state,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);
    occ_e              r_state,     w_state_d;
    logic              r_ready,     w_ready_d;
    logic [DATA_W-1:0] r_main_data, w_main_data_d;
    logic [CTRL_W-1:0] r_main_ctrl, w_main_ctrl_d;
`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] r_skid_data, w_skid_data_d;
    logic [CTRL_W-1:0] r_skid_ctrl, w_skid_ctrl_d;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_main_data_d = r_main_data;
        w_main_ctrl_d = r_main_ctrl;
`ifdef PIPE_SKID_EN
        w_skid_data_d = r_skid_data;
        w_skid_ctrl_d = r_skid_ctrl;
`endif
        if (i_clear) begin
            w_state_d     = StEmpty;
            w_main_data_d = '0;
            w_main_ctrl_d = CTRL_NOP;
`ifdef PIPE_SKID_EN
            w_skid_data_d = '0;
            w_skid_ctrl_d = CTRL_NOP;
`endif
        end else begin
            case (r_state)
                StEmpty: begin
                    if (i_push) begin
                        w_state_d     = StOne;
                        w_main_data_d = i_data;
                        w_main_ctrl_d = i_ctrl;
                    end
                end
                StOne: begin
                    if (i_push && i_pop) begin
                        w_main_data_d = i_data;
                        w_main_ctrl_d = i_ctrl;
                    end else if (i_pop) begin
                        w_state_d     = StEmpty;
                        w_main_data_d = '0;
                        w_main_ctrl_d = CTRL_NOP;
`ifdef PIPE_SKID_EN
                    end else if (i_push) begin
                        w_state_d     = StTwo;
                        w_skid_data_d = i_data;
                        w_skid_ctrl_d = i_ctrl;
`endif
                    end
                end
`ifdef PIPE_SKID_EN
                StTwo: begin
                    // Skid entry is older than anything that can arrive, so it moves up in order.
                    if (i_pop) begin
                        w_state_d     = StOne;
                        w_main_data_d = r_skid_data;
                        w_main_ctrl_d = r_skid_ctrl;
                        w_skid_data_d = '0;
                        w_skid_ctrl_d = CTRL_NOP;
                    end
                end
`endif
                default: begin
                    w_state_d     = StEmpty;
                    w_main_data_d = '0;
                    w_main_ctrl_d = CTRL_NOP;
                end
            endcase
        end
`ifdef PIPE_SKID_EN
        w_ready_d = (w_state_d != StTwo);
`else
        // Single-entry build: this only marks that reset has been left behind.
        w_ready_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StEmpty;
            r_ready     <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= CTRL_NOP;
`ifdef PIPE_SKID_EN
            r_skid_data <= '0;
            r_skid_ctrl <= CTRL_NOP;
`endif
        end else begin
            r_state     <= w_state_d;
            r_ready     <= w_ready_d;
            r_main_data <= w_main_data_d;
            r_main_ctrl <= w_main_ctrl_d;
`ifdef PIPE_SKID_EN
            r_skid_data <= w_skid_data_d;
            r_skid_ctrl <= w_skid_ctrl_d;
`endif
        end
    end

    assign o_state = r_state;
    assign o_ready = r_ready;
    assign o_data  = r_main_data;
    assign o_ctrl  = r_main_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: stall/flush/bubble control around pipe_skid_buf.
// Macro PIPE_SKID_EN selects the registered-ready two-entry skid variant.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_stage_reg_if.slave    bus
);
    occ_e              w_state;
    logic              w_ready_q;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic              w_block;
    logic              w_out_valid;
    logic              w_in_ready;
    logic              w_push;
    logic              w_pop;

    // Stall and flush both freeze the handshake; flush additionally clears storage.
    assign w_block     = bus.stall | bus.flush;
    assign w_out_valid = (w_state != StEmpty) & ~w_block;
`ifdef PIPE_SKID_EN
    assign w_in_ready  = w_ready_q & ~w_block;
`else
    assign w_in_ready  = w_ready_q & ~w_block & (~w_out_valid | bus.out_ready);
`endif
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    pipe_skid_buf #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (bus.flush),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_data   (bus.in_data),
        .i_ctrl   (bus.in_ctrl),
        .o_state  (w_state),
        .o_ready  (w_ready_q),
        .o_data   (w_main_data),
        .o_ctrl   (w_main_ctrl)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_main_data : '0;
    assign bus.out_ctrl  = w_out_valid ? w_main_ctrl : CTRL_NOP;
    assign bus.occupancy = w_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg; expectations follow PIPE_SKID_EN.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int unsigned   DW  = 32;
    localparam int unsigned   CW  = 16;
    localparam logic [CW-1:0] NOP = 16'h0013;
`ifdef PIPE_SKID_EN
    localparam logic [63:0]   OccFull = 64'd2;
`else
    localparam logic [63:0]   OccFull = 64'd1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [DW+CW-1:0] q_exp[$];

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

    pipe_stage_reg #(
        .DATA_W   (DW),
        .CTRL_W   (CW),
        .CTRL_NOP (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_ctrl  = d[CW-1:0] ^ 16'h8000;
    endtask

    // Sample handshakes mid-cycle, then advance to just after the next rising edge.
    task automatic cycle();
        logic [DW+CW-1:0] exp;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            exp = (q_exp.size() > 0) ? q_exp.pop_front() : '1;
            chk("sb_data", 64'({bus.out_ctrl, bus.out_data}), 64'(exp));
        end
        if (bus.in_valid && bus.in_ready) q_exp.push_back({bus.in_ctrl, bus.in_data});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_occ"},  64'(bus.occupancy), 64'd0);
        chk({tag, "_vld"},  64'(bus.out_valid), 64'd0);
        chk({tag, "_data"}, 64'(bus.out_data),  64'd0);
        chk({tag, "_ctrl"}, 64'(bus.out_ctrl),  64'(NOP));
    endtask

    initial begin
        drive(1'b0, 32'h0);
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset and release
        #3;
        chk_idle("rst");
        chk("rst_rdy", 64'(bus.in_ready), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rdy_pre_edge", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 chk("rdy_post_edge", 64'(bus.in_ready), 64'd1);

        // Streaming, one-cycle latency
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i));
            cycle();
            chk("stream_lat", 64'(bus.out_data), 64'(i));
            chk("stream_rdy", 64'(bus.in_ready), 64'd1);
        end
        drive(1'b0, 32'h0);
        cycle();
        chk("stream_drain", 64'(bus.occupancy), 64'd0);

        // Backpressure
        bus.out_ready = 1'b0;
`ifdef PIPE_SKID_EN
        drive(1'b1, 32'hA); cycle();
        chk("bp_occ_a", 64'(bus.occupancy), 64'd1);
        chk("bp_rdy_a", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 32'hB); cycle();
        chk("bp_occ_b", 64'(bus.occupancy), 64'd2);
        chk("bp_rdy_b", 64'(bus.in_ready), 64'd0);
        chk("bp_head",  64'(bus.out_data), 64'hA);
        drive(1'b1, 32'hC); cycle();
        chk("bp_occ_c", 64'(bus.occupancy), 64'd2);
        chk("bp_q",     64'(q_exp.size()), 64'd2);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_rel_occ", 64'(bus.occupancy), 64'd1);
        chk("bp_rel_rdy", 64'(bus.in_ready), 64'd1);
        chk("bp_rel_b",   64'(bus.out_data), 64'hB);
        cycle();
`else
        drive(1'b1, 32'hA); cycle();
        chk("bp_occ_a", 64'(bus.occupancy), 64'd1);
        chk("bp_rdy_a", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 32'hB); cycle();
        chk("bp_occ_b", 64'(bus.occupancy), 64'd1);
        chk("bp_q",     64'(q_exp.size()), 64'd1);
        bus.out_ready = 1'b1;
        #1 chk("bp_rdy_follow_hi", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
        #1 chk("bp_rdy_follow_lo", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_rel_occ", 64'(bus.occupancy), 64'd1);
        chk("bp_rel_b",   64'(bus.out_data), 64'hB);
        drive(1'b1, 32'hC); cycle();
`endif
        chk("bp_c", 64'(bus.out_data), 64'hC);
        drive(1'b0, 32'h0); cycle();
        chk("bp_drain", 64'(bus.occupancy), 64'd0);

        // Stall holds an entry and blocks both sides
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h55); cycle();
        bus.stall = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h66);
        #1;
        chk("stall_vld",  64'(bus.out_valid), 64'd0);
        chk("stall_rdy",  64'(bus.in_ready),  64'd0);
        chk("stall_ctrl", 64'(bus.out_ctrl),  64'(NOP));
        repeat (3) begin
            cycle();
            chk("stall_occ", 64'(bus.occupancy), 64'd1);
        end
        bus.stall = 1'b0;
        drive(1'b0, 32'h0);
        #1;
        chk("stall_rel_vld",  64'(bus.out_valid), 64'd1);
        chk("stall_rel_data", 64'(bus.out_data),  64'h55);
        cycle();
        chk("stall_drain", 64'(bus.occupancy), 64'd0);

        // Flush wins over stall
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h10); cycle();
        drive(1'b1, 32'h20); cycle();
        chk("fl_occ_pre", 64'(bus.occupancy), OccFull);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h30);
        #1;
        chk("fl_rdy", 64'(bus.in_ready),  64'd0);
        chk("fl_vld", 64'(bus.out_valid), 64'd0);
        cycle();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        drive(1'b0, 32'h0);
        #1;
        chk_idle("fl_post");
        q_exp.delete();
        cycle();
        chk("fl_quiet", 64'(bus.occupancy), 64'd0);

        // Asynchronous reset mid-cycle while full
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h40); cycle();
        drive(1'b1, 32'h41); cycle();
        chk("ar_occ_pre", 64'(bus.occupancy), OccFull);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("ar");
        chk("ar_rdy", 64'(bus.in_ready), 64'd0);
        q_exp.delete();
        drive(1'b0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_rdy_up", 64'(bus.in_ready), 64'd1);
        chk("ar_occ",    64'(bus.occupancy), 64'd0);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h77); cycle();
        chk("ar_new", 64'(bus.out_data), 64'h77);
        drive(1'b0, 32'h0); cycle();
        chk("ar_drain", 64'(bus.occupancy), 64'd0);
        chk("sb_left",  64'(q_exp.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
